// File: rtl/umi_arb_pkg.sv
// Shared constants and helpers for the UMI TX round-robin arbiter.
package umi_arb_pkg;

  localparam int unsigned BurstW = 8;
  localparam int unsigned UmiDw  = 256;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/umi_rr_pick.sv
// Rotating priority encoder: first set bit of i_req at or after i_start, wrapping modulo N.
module umi_rr_pick import umi_arb_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int unsigned w_pos;

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = {{(32 - IW){1'b0}}, i_start} + 32'(k);
      if (w_pos >= N) w_pos = w_pos - N;
      if (i_req[w_pos[IW-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/umi_tx_arbiter.sv
// Round-robin arbiter sharing one registered UMI TX port among N requesters,
// with a per-winner burst limit of MAX_BURST consecutive packets.
module umi_tx_arbiter import umi_arb_pkg::*; #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = UmiDw,
  parameter int unsigned MAX_BURST = 1,
  localparam int unsigned IW       = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] umi_packet_in,
  input  logic [N-1:0]    umi_valid_in,
  output logic [N-1:0]    umi_ready_in,
  output logic [DW-1:0]   umi_packet_out,
  output logic            umi_valid_out,
  input  logic            umi_ready_out,
  output logic [IW-1:0]   grant_id
);

  localparam logic [IW-1:0]     LastIdx  = IW'(N - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);

  logic [DW-1:0]     w_pkts [N];
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_grant;
  logic [BurstW-1:0] r_burst_cnt;
  logic [DW-1:0]     r_pkt;
  logic              r_valid;
  logic [IW-1:0]     w_start;
  logic [IW-1:0]     w_pick_idx;
  logic [IW-1:0]     w_winner;
  logic              w_found;
  logic              w_burst_ok;
  logic              w_load;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign w_pkts[i] = umi_packet_in[i*DW +: DW];
  end

  assign w_start = (r_ptr == LastIdx) ? '0 : r_ptr + 1'b1;

  umi_rr_pick #(
    .N (N)
  ) u_pick (
    .i_req   (umi_valid_in),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  // The last winner keeps the port while valid and under its burst limit.
  assign w_burst_ok = r_burst_cnt < BurstMax;
  assign w_winner   = (umi_valid_in[r_ptr] && w_burst_ok) ? r_ptr : w_pick_idx;
  assign w_load     = (!r_valid || umi_ready_out) && w_found;

  always_comb begin
    umi_ready_in = '0;
    if (w_load && !rst) umi_ready_in[w_winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pkt       <= '0;
      r_grant     <= '0;
      r_ptr       <= LastIdx;
      r_burst_cnt <= BurstMax;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_pkt       <= w_pkts[w_winner];
      r_grant     <= w_winner;
      r_ptr       <= w_winner;
      r_burst_cnt <= (w_winner == r_ptr && w_burst_ok) ? r_burst_cnt + 1'b1 : BurstW'(1);
    end else if (umi_ready_out) begin
      r_valid <= 1'b0;
    end
  end

  assign umi_packet_out = r_pkt;
  assign umi_valid_out  = r_valid;
  assign grant_id       = r_grant;

endmodule

// File: tb/tb_umi_tx_arbiter.sv
// Scoreboard bench: three arbiters (MAX_BURST 1..3) share one random stimulus stream,
// each checked against a round-robin reference model.
module tb_umi_tx_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned IW   = 2;
  localparam int          NDUT = 3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] pkt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] pkt_in = '0;
  logic [N-1:0]    vin = '0;
  logic            rdy_out = 1'b0;

  logic [N-1:0]  ready_in [NDUT];
  logic [DW-1:0] pkt_out  [NDUT];
  logic          vout     [NDUT];
  logic [IW-1:0] gid      [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    umi_tx_arbiter #(
      .N         (N),
      .DW        (DW),
      .MAX_BURST (g + 1)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .umi_packet_in  (pkt_in),
      .umi_valid_in   (vin),
      .umi_ready_in   (ready_in[g]),
      .umi_packet_out (pkt_out[g]),
      .umi_valid_out  (vout[g]),
      .umi_ready_out  (rdy_out),
      .grant_id       (gid[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  bit          mode_rand = 1'b1;
  logic [N-1:0] cur_mask = '0;
  bit          cur_rdy   = 1'b0;
  bit          force_a5  = 1'b0;

  // Reference model state, one slot per arbiter instance.
  bit           m_valid   [NDUT];
  int           m_last    [NDUT];
  int           m_cnt     [NDUT];
  bit           p_load    [NDUT];
  int           p_win     [NDUT];
  bit           p_drain   [NDUT];
  logic [N-1:0] exp_ready [NDUT];
  exp_t         exp_q     [NDUT][$];
  int unsigned  glog      [NDUT][$];

  int unsigned seq_rr1  [9] = '{0, 1, 2, 3, 0, 1, 0, 0, 0};
  int unsigned seq_rr2  [9] = '{0, 0, 1, 1, 2, 2, 0, 0, 0};
  int unsigned seq_rr3  [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  int unsigned seq_p1   [9] = '{0, 2, 0, 2, 0, 2, 0, 0, 0};
  int unsigned seq_p2   [9] = '{0, 0, 2, 2, 0, 0, 0, 0, 0};
  int unsigned seq_p3   [9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
  int unsigned seq_sole [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_seq(input string nm, input int g, input int n, input int unsigned e [9]);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", nm, i),
          (i < int'(glog[g].size())) ? 64'(glog[g][i]) : 64'hFFFF, 64'(e[i]));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < NDUT; g++) glog[g].delete();
  endtask

  // Driver + model: runs 2 time units after each edge, commits the decision taken for
  // that edge, then drives new inputs and predicts the next edge.
  initial begin
    logic [DW-1:0] pk [N];
    exp_t          e;
    bit            found;
    int            win;
    int            idx;
    for (int g = 0; g < NDUT; g++) begin
      exp_ready[g] = '0;
      m_valid[g]   = 1'b0;
      m_last[g]    = N - 1;
      m_cnt[g]     = g + 1;
      p_load[g]    = 1'b0;
      p_drain[g]   = 1'b0;
      p_win[g]     = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < NDUT; g++) begin
        if (rst) begin
          m_valid[g] = 1'b0;
          m_last[g]  = N - 1;
          m_cnt[g]   = g + 1;
          p_load[g]  = 1'b0;
          p_drain[g] = 1'b0;
          exp_q[g].delete();
        end else if (p_load[g]) begin
          if (p_win[g] == m_last[g] && m_cnt[g] < g + 1) m_cnt[g] = m_cnt[g] + 1;
          else m_cnt[g] = 1;
          m_last[g]  = p_win[g];
          m_valid[g] = 1'b1;
        end else if (p_drain[g]) begin
          m_valid[g] = 1'b0;
        end
      end
      if (mode_rand) begin
        vin     = N'($urandom);
        rdy_out = ($urandom_range(0, 9) < 7);
      end else begin
        vin     = cur_mask;
        rdy_out = cur_rdy;
      end
      for (int i = 0; i < N; i++) begin
        pk[i] = {$urandom, $urandom};
        if (force_a5 && i == 2) pk[i] = 64'hA5;
        pkt_in[i*DW +: DW] = pk[i];
      end
      for (int g = 0; g < NDUT; g++) begin
        exp_ready[g] = '0;
        p_load[g]    = 1'b0;
        p_drain[g]   = 1'b0;
        if (!rst) begin
          found = 1'b0;
          win   = 0;
          if (vin[m_last[g]] && m_cnt[g] < g + 1) begin
            found = 1'b1;
            win   = m_last[g];
          end else begin
            for (int off = 1; off <= N; off++) begin
              idx = (m_last[g] + off) % N;
              if (!found && vin[idx]) begin
                found = 1'b1;
                win   = idx;
              end
            end
          end
          if (found && (!m_valid[g] || rdy_out)) begin
            p_load[g]    = 1'b1;
            p_win[g]     = win;
            exp_ready[g] = N'(1) << win;
            e.id         = IW'(win);
            e.pkt        = pk[win];
            exp_q[g].push_back(e);
          end else begin
            p_drain[g] = m_valid[g] && rdy_out;
          end
        end
      end
    end
  end

  // Monitor: compares on the falling edge, pops on each downstream transfer.
  initial begin
    exp_t f;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (rst) begin
          chk($sformatf("dut%0d rst ready_in", g), 64'(ready_in[g]), 64'(0));
          chk($sformatf("dut%0d rst valid_out", g), 64'(vout[g]), 64'(0));
          chk($sformatf("dut%0d rst packet_out", g), 64'(pkt_out[g]), 64'(0));
          chk($sformatf("dut%0d rst grant_id", g), 64'(gid[g]), 64'(0));
        end else begin
          chk($sformatf("dut%0d ready_in", g), 64'(ready_in[g]), 64'(exp_ready[g]));
          chk($sformatf("dut%0d valid_out", g), 64'(vout[g]), 64'(m_valid[g]));
          if (vout[g] && m_valid[g]) begin
            if (exp_q[g].size() == 0) begin
              n_total++;
              $display("FAIL dut%0d scoreboard: got output id %0d, expected no pending packet",
                       g, gid[g]);
            end else begin
              f = exp_q[g][0];
              chk($sformatf("dut%0d packet_out", g), 64'(pkt_out[g]), 64'(f.pkt));
              chk($sformatf("dut%0d grant_id", g), 64'(gid[g]), 64'(f.id));
              if (rdy_out) begin
                glog[g].push_back(32'(gid[g]));
                void'(exp_q[g].pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);

    // All valid, free-running downstream.
    do_reset();
    mode_rand = 1'b0;
    cur_mask  = 4'hF;
    cur_rdy   = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk_seq("rr_mb1", 0, 6, seq_rr1);
    chk_seq("rr_mb2", 1, 6, seq_rr2);
    chk_seq("rr_mb3", 2, 6, seq_rr3);

    // Backpressure with req2's 0xA5 held in the output register.
    do_reset();
    cur_mask = 4'b0100;
    force_a5 = 1'b1;
    cur_rdy  = 1'b0;
    @(posedge clk);
    #1 cur_mask = 4'hF;
    repeat (5) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("bp dut%0d packet", g), 64'(pkt_out[g]), 64'hA5);
        chk($sformatf("bp dut%0d grant", g), 64'(gid[g]), 64'(2));
        chk($sformatf("bp dut%0d ready_in", g), 64'(ready_in[g]), 64'(0));
      end
    end
    cur_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1 force_a5 = 1'b0;
    chk("bp mb1 first", (glog[0].size() > 0) ? 64'(glog[0][0]) : 64'hFFFF, 64'(2));
    chk("bp mb1 next", (glog[0].size() > 1) ? 64'(glog[0][1]) : 64'hFFFF, 64'(3));
    chk("bp mb3 next", (glog[2].size() > 1) ? 64'(glog[2][1]) : 64'hFFFF, 64'(2));

    // Only req0 and req2 valid.
    do_reset();
    cur_mask = 4'b0101;
    cur_rdy  = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    chk_seq("pair_mb1", 0, 6, seq_p1);
    chk_seq("pair_mb2", 1, 6, seq_p2);
    chk_seq("pair_mb3", 2, 9, seq_p3);

    // Sole requester: back-to-back grants, then valid drops.
    do_reset();
    cur_mask = 4'b0010;
    cur_rdy  = 1'b1;
    repeat (6) @(posedge clk);
    #1 cur_mask = 4'b0000;
    @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("sole dut%0d valid drop", g), 64'(vout[g]), 64'(0));
    chk("sole mb2 count", 64'(glog[1].size()), 64'(6));
    chk_seq("sole_mb2", 1, 6, seq_sole);

    // Asynchronous reset while stalled.
    do_reset();
    cur_mask = 4'hF;
    cur_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("stall dut%0d valid", g), 64'(vout[g]), 64'(1));
    rst = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("arst dut%0d valid", g), 64'(vout[g]), 64'(0));
      chk($sformatf("arst dut%0d packet", g), 64'(pkt_out[g]), 64'(0));
      chk($sformatf("arst dut%0d grant", g), 64'(gid[g]), 64'(0));
      chk($sformatf("arst dut%0d ready_in", g), 64'(ready_in[g]), 64'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < NDUT; g++) glog[g].delete();
    cur_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("arst dut%0d first grant", g),
          (glog[g].size() > 0) ? 64'(glog[g][0]) : 64'hFFFF, 64'(0));

    // Random valids and backpressure.
    do_reset();
    mode_rand = 1'b1;
    repeat (600) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
